mem_access_unit: RTL and testbench

Memory-stage load/store engine for the pipelined RV32I core. It accepts one memory operation per request from the MEM stage, already decoded as store-enable, load-enable and funct3 width code. It drives a valid/ready data-memory port with aligned word address, byte enables and lane-replicated store data, then sign- or zero-extends the returned load data. It stalls the pipeline while the access is outstanding and flags misaligned or illegal-width accesses without touching memory.

---
 rtl/riscv_mem_pkg.sv | 22 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory-stage load/store engine.
package riscv_mem_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned BE_W   = XLEN / 8;
   localparam int unsigned LSEL_W = 2;

   // funct3 width codes for loads and stores
   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } mau_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store enables/replication, load extraction, fault detect.
module lsu_align
   import riscv_mem_pkg::*;
(
   input  logic [2:0]        ls_type,
   input  logic [LSEL_W-1:0] addr_lo,
   input  logic [XLEN-1:0]   wdata,
   input  logic [XLEN-1:0]   rdata,
   output logic [BE_W-1:0]   be_c,
   output logic [XLEN-1:0]   wdata_c,
   output logic [XLEN-1:0]   rdata_c,
   output logic              fault_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // pick the addressed byte and halfword out of the returned word
   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // width decode: lanes, replication, extension and alignment fault
   always_comb begin
      be_c    = '0;
      wdata_c = '0;
      rdata_c = '0;
      fault_c = 1'b0;
      unique case (ls_type)
         LS_B, LS_BU: begin
            be_c    = BE_W'(4'b0001 << addr_lo);
            wdata_c = {4{wdata[7:0]}};
            rdata_c = (ls_type == LS_B) ? {{24{byte_sel[7]}}, byte_sel}
                                        : {24'd0, byte_sel};
         end
         LS_H, LS_HU: begin
            fault_c = addr_lo[0];
            be_c    = BE_W'(4'b0011 << {addr_lo[1], 1'b0});
            wdata_c = {2{wdata[15:0]}};
            rdata_c = (ls_type == LS_H) ? {{16{half_sel[15]}}, half_sel}
                                        : {16'd0, half_sel};
         end
         LS_W: begin
            fault_c = (addr_lo != 2'b00);
            be_c    = 4'b1111;
            wdata_c = wdata;
            rdata_c = rdata;
         end
         default: begin
            fault_c = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: request capture, dmem handshake, response.
module mem_access_unit
   import riscv_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              mem_write,
   input  logic              mem_read,
   input  logic [2:0]        ls_type,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_fault,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic              dmem_we,
   output logic [BE_W-1:0]   dmem_be,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   input  logic              dmem_rsp_valid,
   input  logic [XLEN-1:0]   dmem_rsp_rdata
);

   mau_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        type_q, type_d;
   logic [LSEL_W-1:0] lo_q, lo_d;

   logic              req_ready_q, req_ready_d;
   logic              stall_q, stall_d;
   logic              resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
   logic              resp_fault_q, resp_fault_d;
   logic              dmem_req_valid_q, dmem_req_valid_d;
   logic              dmem_we_q, dmem_we_d;
   logic [BE_W-1:0]   dmem_be_q, dmem_be_d;
   logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
   logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;

   logic [2:0]        al_type;
   logic [LSEL_W-1:0] al_lo;
   logic [BE_W-1:0]   al_be;
   logic [XLEN-1:0]   al_wdata;
   logic [XLEN-1:0]   al_rdata;
   logic              al_fault;

   // aligner sees the live request while idle, the captured op otherwise
   always_comb begin
      al_type = (state_q == ST_IDLE) ? ls_type : type_q;
      al_lo   = (state_q == ST_IDLE) ? addr[1:0] : lo_q;
   end

   lsu_align u_align (
      .ls_type (al_type),
      .addr_lo (al_lo),
      .wdata   (wdata),
      .rdata   (dmem_rsp_rdata),
      .be_c    (al_be),
      .wdata_c (al_wdata),
      .rdata_c (al_rdata),
      .fault_c (al_fault)
   );

   // next-state and next-output computation
   always_comb begin
      state_d          = state_q;
      we_d             = we_q;
      type_d           = type_q;
      lo_d             = lo_q;
      resp_rdata_d     = '0;
      resp_fault_d     = 1'b0;
      dmem_req_valid_d = 1'b0;
      dmem_we_d        = dmem_we_q;
      dmem_be_d        = dmem_be_q;
      dmem_addr_d      = dmem_addr_q;
      dmem_wdata_d     = dmem_wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d   = mem_write;
               type_d = ls_type;
               lo_d   = addr[1:0];
               if (al_fault) begin
                  state_d      = ST_DONE;
                  resp_fault_d = 1'b1;
               end else if (!(mem_read || mem_write)) begin
                  state_d = ST_DONE;
               end else begin
                  // a store wins when both read and write are flagged
                  state_d          = ST_REQ;
                  dmem_req_valid_d = 1'b1;
                  dmem_we_d        = mem_write;
                  dmem_be_d        = al_be;
                  dmem_addr_d      = {addr[ADDR_W-1:2], 2'b00};
                  dmem_wdata_d     = mem_write ? al_wdata : '0;
               end
            end
         end
         ST_REQ: begin
            if (dmem_req_ready) begin
               state_d      = we_q ? ST_DONE : ST_WAIT;
               dmem_we_d    = 1'b0;
               dmem_be_d    = '0;
               dmem_addr_d  = '0;
               dmem_wdata_d = '0;
            end else begin
               dmem_req_valid_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (dmem_rsp_valid) begin
               state_d      = ST_DONE;
               resp_rdata_d = al_rdata;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d  = (state_d == ST_IDLE);
      stall_d      = (state_d != ST_IDLE);
      resp_valid_d = (state_d == ST_DONE);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         we_q             <= 1'b0;
         type_q           <= '0;
         lo_q             <= '0;
         req_ready_q      <= 1'b1;
         stall_q          <= 1'b0;
         resp_valid_q     <= 1'b0;
         resp_rdata_q     <= '0;
         resp_fault_q     <= 1'b0;
         dmem_req_valid_q <= 1'b0;
         dmem_we_q        <= 1'b0;
         dmem_be_q        <= '0;
         dmem_addr_q      <= '0;
         dmem_wdata_q     <= '0;
      end else begin
         state_q          <= state_d;
         we_q             <= we_d;
         type_q           <= type_d;
         lo_q             <= lo_d;
         req_ready_q      <= req_ready_d;
         stall_q          <= stall_d;
         resp_valid_q     <= resp_valid_d;
         resp_rdata_q     <= resp_rdata_d;
         resp_fault_q     <= resp_fault_d;
         dmem_req_valid_q <= dmem_req_valid_d;
         dmem_we_q        <= dmem_we_d;
         dmem_be_q        <= dmem_be_d;
         dmem_addr_q      <= dmem_addr_d;
         dmem_wdata_q     <= dmem_wdata_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign stall          = stall_q;
   assign resp_valid     = resp_valid_q;
   assign resp_rdata     = resp_rdata_q;
   assign resp_fault     = resp_fault_q;
   assign dmem_req_valid = dmem_req_valid_q;
   assign dmem_we        = dmem_we_q;
   assign dmem_be        = dmem_be_q;
   assign dmem_addr      = dmem_addr_q;
   assign dmem_wdata     = dmem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, corner sequences, random ops.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, mem_write, mem_read;
   logic [2:0]  ls_type;
   logic [31:0] addr, wdata;
   logic        stall, resp_valid, resp_fault;
   logic [31:0] resp_rdata;
   logic        dmem_req_valid, dmem_req_ready, dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .ls_type        (ls_type),
      .addr           (addr),
      .wdata          (wdata),
      .stall          (stall),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_fault     (resp_fault),
      .dmem_req_valid (dmem_req_valid),
      .dmem_req_ready (dmem_req_ready),
      .dmem_we        (dmem_we),
      .dmem_be        (dmem_be),
      .dmem_addr      (dmem_addr),
      .dmem_wdata     (dmem_wdata),
      .dmem_rsp_valid (dmem_rsp_valid),
      .dmem_rsp_rdata (dmem_rsp_rdata)
   );

   typedef struct {
      logic        wr;
      logic        rd;
      logic [2:0]  t;
      logic [31:0] addr;
      logic [31:0] wd;
      int          rdy;
      int          rsp;
      logic [31:0] word;
      int          exp_lat;
      logic [31:0] exp_rdata;
      logic        exp_fault;
      logic [3:0]  exp_be;
      logic [31:0] exp_dw;
   } vec_t;

   typedef struct {
      int          lat;
      logic [31:0] rdata;
      logic        fault;
      logic        saw;
      logic        stable;
      logic        stall_ok;
      logic [3:0]  be;
      logic [31:0] daddr;
      logic [31:0] dw;
      logic        we;
      logic [2:0]  after;
   } obs_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic wr, input logic rd, input logic [2:0] t,
                                input logic [31:0] a, input logic [31:0] wd,
                                input int rdy, input int rsp, input logic [31:0] word,
                                input int lat, input logic [31:0] rdata, input logic fault,
                                input logic [3:0] be, input logic [31:0] dw);
      vec_t v;
      v.wr = wr; v.rd = rd; v.t = t; v.addr = a; v.wd = wd;
      v.rdy = rdy; v.rsp = rsp; v.word = word;
      v.exp_lat = lat; v.exp_rdata = rdata; v.exp_fault = fault;
      v.exp_be = be; v.exp_dw = dw;
      return v;
   endfunction

   // reference model: access size, alignment and extension from plain arithmetic
   function automatic vec_t model(input vec_t v);
      vec_t   r;
      int     sz, sh;
      bit     sgn, ill;
      longint val, mask;
      r = v; sz = 1; sgn = 0; ill = 0;
      case (v.t)
         3'd0: begin sz = 1; sgn = 1; end
         3'd1: begin sz = 2; sgn = 1; end
         3'd2: sz = 4;
         3'd4: sz = 1;
         3'd5: sz = 2;
         default: ill = 1;
      endcase
      sh = int'(v.addr[1:0]);
      r.exp_fault = ill || ((sh % sz) != 0);
      r.exp_be    = 4'(((1 << sz) - 1) << sh);
      if (sz == 1)      r.exp_dw = {24'd0, v.wd[7:0]} * 32'h01010101;
      else if (sz == 2) r.exp_dw = {16'd0, v.wd[15:0]} * 32'h00010001;
      else              r.exp_dw = v.wd;
      r.exp_rdata = '0;
      if (r.exp_fault || !(v.rd || v.wr)) r.exp_lat = 1;
      else if (v.wr) r.exp_lat = 2 + v.rdy;
      else begin
         r.exp_lat = 3 + v.rdy + v.rsp;
         mask = (longint'(1) << (8 * sz)) - 1;
         val  = longint'(v.word >> (8 * sh)) & mask;
         if (sgn && val > (mask >> 1)) val = val - mask - 1;
         r.exp_rdata = 32'(val);
      end
      return r;
   endfunction

   // issue one op, play the memory side, and record what the DUT did
   task automatic run_op(input vec_t v, output obs_t o);
      int   nreq, nw;
      logic acc;
      o.lat = 0; o.rdata = '0; o.fault = 1'b0; o.saw = 1'b0; o.stable = 1'b1;
      o.stall_ok = 1'b1; o.be = '0; o.daddr = '0; o.dw = '0; o.we = 1'b0; o.after = '0;
      req_valid = 1'b1; mem_write = v.wr; mem_read = v.rd;
      ls_type = v.t; addr = v.addr; wdata = v.wd;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_write = 1'($urandom); mem_read = 1'($urandom);
      ls_type = 3'($urandom); addr = $urandom; wdata = $urandom;
      nreq = 0; nw = 0; acc = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = $urandom;
         if (resp_valid) begin
            o.lat = k; o.rdata = resp_rdata; o.fault = resp_fault;
            break;
         end
         if (!stall) o.stall_ok = 1'b0;
         if (dmem_req_valid) begin
            if (!o.saw) begin
               o.be = dmem_be; o.daddr = dmem_addr; o.dw = dmem_wdata; o.we = dmem_we;
            end else if ({dmem_be, dmem_addr, dmem_wdata, dmem_we} !== {o.be, o.daddr, o.dw, o.we}) begin
               o.stable = 1'b0;
            end
            o.saw = 1'b1;
            dmem_rsp_valid = 1'($urandom);
            if (nreq >= v.rdy) begin
               dmem_req_ready = 1'b1;
               acc = 1'b1;
            end
            nreq++;
         end else if (acc && v.rd && !v.wr) begin
            if (nw >= v.rsp) begin
               dmem_rsp_valid = 1'b1;
               dmem_rsp_rdata = v.word;
            end
            nw++;
         end
         @(posedge clk); #1;
      end
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
      @(posedge clk); #1;
      o.after = {resp_valid, req_ready, stall};
   endtask

   task automatic apply_vec(input vec_t v, input string nm);
      obs_t o;
      logic mem;
      run_op(v, o);
      mem = !v.exp_fault && (v.rd || v.wr);
      check({nm, ".latency"}, 32'(o.lat), 32'(v.exp_lat));
      check({nm, ".rdata"}, o.rdata, v.exp_rdata);
      check({nm, ".fault"}, 32'(o.fault), 32'(v.exp_fault));
      check({nm, ".dmem_req_seen"}, 32'(o.saw), 32'(mem));
      check({nm, ".stall_busy"}, 32'(o.stall_ok), 32'd1);
      check({nm, ".idle_after"}, 32'(o.after), 32'b010);
      if (o.saw && mem) begin
         check({nm, ".dmem_addr"}, o.daddr, v.addr & 32'hFFFF_FFFC);
         check({nm, ".dmem_be"}, 32'(o.be), 32'(v.exp_be));
         check({nm, ".dmem_we"}, 32'(o.we), 32'(v.wr));
         check({nm, ".dmem_stable"}, 32'(o.stable), 32'd1);
         if (v.wr) check({nm, ".dmem_wdata"}, o.dw, v.exp_dw);
      end
   endtask

   vec_t tbl[13];
   vec_t rv;
   logic seen;

   initial begin
      rst = 1'b1; req_valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
      ls_type = '0; addr = '0; wdata = '0;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;

      tbl[0]  = mkv(1, 0, 3'd0, 32'h1003, 32'hA5, 0, 0, 32'h0, 2, 32'h0, 0, 4'b1000, 32'hA5A5A5A5);
      tbl[1]  = mkv(0, 1, 3'd1, 32'h2002, 32'h0, 0, 0, 32'h80011234, 3, 32'hFFFF8001, 0, 4'b1100, 32'h0);
      tbl[2]  = mkv(0, 1, 3'd5, 32'h2002, 32'h0, 0, 0, 32'h80011234, 3, 32'h00008001, 0, 4'b1100, 32'h0);
      tbl[3]  = mkv(0, 1, 3'd2, 32'h3001, 32'h0, 0, 0, 32'h0, 1, 32'h0, 1, 4'b0000, 32'h0);
      tbl[4]  = mkv(0, 1, 3'd7, 32'h3000, 32'h0, 0, 0, 32'h0, 1, 32'h0, 1, 4'b0000, 32'h0);
      tbl[5]  = mkv(1, 0, 3'd2, 32'h4000, 32'h12345678, 3, 0, 32'h0, 5, 32'h0, 0, 4'b1111, 32'h12345678);
      tbl[6]  = mkv(0, 1, 3'd0, 32'h11, 32'h0, 0, 2, 32'h0000F000, 5, 32'hFFFFFFF0, 0, 4'b0010, 32'h0);
      tbl[7]  = mkv(1, 0, 3'd1, 32'h22, 32'hBEEF, 0, 0, 32'h0, 2, 32'h0, 0, 4'b1100, 32'hBEEFBEEF);
      tbl[8]  = mkv(0, 0, 3'd2, 32'h5000, 32'h0, 0, 0, 32'h0, 1, 32'h0, 0, 4'b0000, 32'h0);
      tbl[9]  = mkv(1, 1, 3'd0, 32'h1, 32'h5A, 0, 0, 32'h0, 2, 32'h0, 0, 4'b0010, 32'h5A5A5A5A);
      tbl[10] = mkv(0, 1, 3'd4, 32'h7, 32'h0, 1, 1, 32'h80000000, 5, 32'h00000080, 0, 4'b1000, 32'h0);
      tbl[11] = mkv(1, 0, 3'd1, 32'h101, 32'h1234, 0, 0, 32'h0, 1, 32'h0, 1, 4'b0000, 32'h0);
      tbl[12] = mkv(0, 1, 3'd2, 32'h3C, 32'h0, 2, 1, 32'hDEADBEEF, 6, 32'hDEADBEEF, 0, 4'b1111, 32'h0);

      // reset values
      repeat (2) @(posedge clk);
      #1;
      check("reset.ctrl", 32'({req_ready, stall, resp_valid, resp_fault, dmem_req_valid, dmem_we}),
            32'b100000);
      check("reset.rdata", resp_rdata, 32'h0);
      check("reset.dmem", 32'({dmem_be, dmem_addr, dmem_wdata} != 68'd0), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

      // reset while a load waits for data; simultaneous response must lose to rst
      req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; ls_type = 3'd0; addr = 32'h40;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_read = 1'b0; dmem_req_ready = 1'b1;
      @(posedge clk); #1;
      dmem_req_ready = 1'b0;
      check("rst_wait.stall_before", 32'(stall), 32'd1);
      rst = 1'b1; dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'h0000007F;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_wait.after", 32'({req_ready, stall, resp_valid, dmem_req_valid}), 32'b1000);
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         seen = seen | resp_valid | stall;
      end
      dmem_rsp_valid = 1'b0;
      check("rst_wait.late_rsp_ignored", 32'(seen), 32'd0);
      apply_vec(mkv(0, 1, 3'd4, 32'h42, 32'h0, 0, 0, 32'h00AB0000, 3, 32'h000000AB, 0, 4'b0100, 32'h0),
                "lbu_after_rst");

      // reset while a store is presented to memory, with ready high the same cycle
      req_valid = 1'b1; mem_write = 1'b1; mem_read = 1'b0; ls_type = 3'd2; addr = 32'h80; wdata = 32'h1;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_write = 1'b0;
      check("rst_req.valid_before", 32'(dmem_req_valid), 32'd1);
      rst = 1'b1; dmem_req_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; dmem_req_ready = 1'b0;
      check("rst_req.after", 32'({dmem_req_valid, stall, req_ready}), 32'b001);
      @(posedge clk); #1;
      check("rst_req.no_resp", 32'(resp_valid), 32'd0);

      // back-to-back: request held high is taken only after the done cycle
      dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hCAFEF00D;
      req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; ls_type = 3'd2; addr = 32'h8;
      @(posedge clk); #1;
      check("b2b.req1", 32'({stall, dmem_req_valid}), 32'b11);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("b2b.done1", 32'({resp_valid, req_ready}), 32'b10);
      check("b2b.rdata1", resp_rdata, 32'hCAFEF00D);
      dmem_rsp_rdata = 32'h0BADC0DE;
      @(posedge clk); #1;
      check("b2b.idle", 32'({resp_valid, req_ready, stall}), 32'b010);
      @(posedge clk); #1;
      check("b2b.req2", 32'({stall, dmem_req_valid, req_ready}), 32'b110);
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("b2b.done2", 32'(resp_valid), 32'd1);
      check("b2b.rdata2", resp_rdata, 32'h0BADC0DE);
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
      @(posedge clk); #1;

      // random operations against the reference model
      for (int i = 0; i < 150; i++) begin
         rv.wr   = 1'($urandom);
         rv.rd   = 1'($urandom);
         rv.t    = 3'($urandom);
         rv.addr = $urandom;
         rv.wd   = $urandom;
         rv.rdy  = int'($urandom_range(0, 3));
         rv.rsp  = int'($urandom_range(0, 3));
         rv.word = $urandom;
         rv = model(rv);
         apply_vec(rv, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
